// File: rtl/sprite_pop_scheduler.sv
// rtl/sprite_pop_scheduler.sv - debounced/auto-timed random sprite position scheduler, frame-synchronous commit
module sprite_pop_scheduler #(
    parameter int H_ACTIVE        = 1280,
    parameter int V_ACTIVE        = 720,
    parameter int SPRITE_W        = 256,
    parameter int SPRITE_H        = 256,
    parameter int DEBOUNCE_CYCLES = 742500
) (
    input  logic        clk_pixel_in,
    input  logic        rst_n_in,
    input  logic        trigger_in,
    input  logic        new_frame_in,
    input  logic [15:0] rand_in,
    input  logic        auto_en_in,
    input  logic [5:0]  auto_period_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        pop_out,
    output logic        update_out,
    output logic        busy_out
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [10:0]     XR      = 11'(H_ACTIVE - SPRITE_W + 1);
    localparam logic [9:0]      YR      = 10'(V_ACTIVE - SPRITE_H + 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FOLD, S_ARM} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [DB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [5:0]        frame_cnt_q, frame_cnt_d;
    logic [10:0]       xr_q, xr_d, x_q, x_d;
    logic [9:0]        yr_q, yr_d, y_q, y_d;
    logic              pend_q, pend_d, pop_q, pop_d;
    logic              update_q, update_d, busy_q, busy_d;
    logic              btn_req, auto_req, req;

    always_comb begin
        sync1_d    = trigger_in;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        deb_prev_d = deb_q;
        // Counter only advances while the synchronised input disagrees with the debounced level
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DB_LAST) begin
                deb_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
        btn_req = deb_q & ~deb_prev_q;

        frame_cnt_d = frame_cnt_q;
        auto_req    = 1'b0;
        if (!auto_en_in || auto_period_in == 6'd0) begin
            frame_cnt_d = '0;
        end else if (new_frame_in) begin
            if (frame_cnt_q + 6'd1 == auto_period_in) begin
                frame_cnt_d = '0;
                auto_req    = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 6'd1;
            end
        end
        req = btn_req | auto_req;

        state_d  = state_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        pend_d   = pend_q;
        x_d      = x_q;
        y_d      = y_q;
        pop_d    = pop_q;
        update_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                xr_d    = rand_in[10:0];
                yr_d    = {rand_in[4:0], rand_in[15:11]};
                pend_d  = rand_in[0];
                state_d = S_FOLD;
            end
            S_FOLD: begin
                if (xr_q >= XR) xr_d = xr_q - XR;
                if (yr_q >= YR) yr_d = yr_q - YR;
                if (xr_q < XR && yr_q < YR) state_d = S_ARM;
            end
            S_ARM: begin
                // Commit only at frame start so the sprite never moves mid-frame
                if (new_frame_in) begin
                    x_d      = xr_q;
                    y_d      = yr_q;
                    pop_d    = pend_q;
                    update_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_prev_q  <= 1'b0;
            deb_cnt_q   <= '0;
            frame_cnt_q <= '0;
            xr_q        <= '0;
            yr_q        <= '0;
            pend_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pop_q       <= 1'b0;
            update_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            xr_q        <= xr_d;
            yr_q        <= yr_d;
            pend_q      <= pend_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pop_q       <= pop_d;
            update_q    <= update_d;
            busy_q      <= busy_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign pop_out    = pop_q;
    assign update_out = update_q;
    assign busy_out   = busy_q;

endmodule

// File: tb/tb_sprite_pop_scheduler.sv
// tb/tb_sprite_pop_scheduler.sv - randomized self-checking bench for sprite_pop_scheduler
module tb_sprite_pop_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trigger;
    logic        new_frame;
    logic [15:0] rand_w;
    logic        auto_en;
    logic [5:0]  auto_period;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        pop_out;
    logic        update_out;
    logic        busy_out;

    int checks = 0;
    int errors = 0;
    int upd_total = 0;

    always #5 clk = ~clk;

    sprite_pop_scheduler #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_pixel_in   (clk),
        .rst_n_in       (rst_n),
        .trigger_in     (trigger),
        .new_frame_in   (new_frame),
        .rand_in        (rand_w),
        .auto_en_in     (auto_en),
        .auto_period_in (auto_period),
        .x_out          (x_out),
        .y_out          (y_out),
        .pop_out        (pop_out),
        .update_out     (update_out),
        .busy_out       (busy_out)
    );

    always @(negedge clk) if (rst_n && update_out) upd_total++;

    // Reference: folding by repeated subtraction is a modulo into the legal range
    function automatic int exp_x(input logic [15:0] r);
        return int'(r[10:0]) % 1025;
    endfunction
    function automatic int exp_y(input logic [15:0] r);
        logic [9:0] v;
        v = {r[4:0], r[15:11]};
        return int'(v) % 465;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [15:0] r);
        rand_w  = r;
        trigger = 1'b1;
        repeat (10) tick();
        trigger = 1'b0;
        repeat (10) tick();
    endtask

    task automatic frame();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic check_commit(input string name, input logic [15:0] r);
        checks++;
        if (update_out !== 1'b1 || int'(x_out) != exp_x(r) || int'(y_out) != exp_y(r) || pop_out !== r[0]) begin
            errors++;
            $display("FAIL %s: upd=%0b x=%0d y=%0d pop=%0b expected upd=1 x=%0d y=%0d pop=%0b",
                     name, update_out, x_out, y_out, pop_out, exp_x(r), exp_y(r), r[0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trigger = 1'b0; new_frame = 1'b0; rand_w = '0;
        auto_en = 1'b0; auto_period = '0;
        repeat (3) tick();
        checks++;
        if ({x_out, y_out, pop_out, update_out, busy_out} !== 24'd0) begin
            errors++;
            $display("FAIL reset_state: x=%0d y=%0d pop=%0b upd=%0b busy=%0b expected all 0",
                     x_out, y_out, pop_out, update_out, busy_out);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_button_fold(input logic [15:0] r, input string name);
        int u0;
        press(r);
        checks++;
        if (busy_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: busy=%0b expected 1", name, busy_out);
        end
        u0 = upd_total;
        frame();
        check_commit(name, r);
        tick();
        checks++;
        if (update_out !== 1'b0 || busy_out !== 1'b0 || upd_total != u0 + 1) begin
            errors++;
            $display("FAIL %s_after: upd=%0b busy=%0b pulses=%0d expected 0 0 1",
                     name, update_out, busy_out, upd_total - u0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) test_button_fold(16'($urandom), "random_fold");
    endtask

    task automatic test_debounce();
        int   u0;
        logic busy_seen;
        logic [15:0] r;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            trigger = 1'((i / 2) % 2);
            tick();
            if (busy_out) busy_seen = 1'b1;
        end
        trigger = 1'b0;
        repeat (10) tick();
        u0 = upd_total;
        frame();
        tick();
        checks++;
        if (busy_seen !== 1'b0 || upd_total != u0) begin
            errors++;
            $display("FAIL debounce_bounce: busy_seen=%0b pulses=%0d expected 0 0", busy_seen, upd_total - u0);
        end
        r = 16'($urandom);
        rand_w  = r;
        trigger = 1'b1;
        repeat (5) tick();
        trigger = 1'b0;
        repeat (12) tick();
        u0 = upd_total;
        frame();
        check_commit("debounce_hold", r);
        frame();
        checks++;
        if (upd_total != u0 + 1) begin
            errors++;
            $display("FAIL debounce_single: pulses=%0d expected 1", upd_total - u0);
        end
    endtask

    task automatic run_auto(input int p, input string name);
        int cnt, u0, commits;
        logic pending, fire;
        logic [15:0] r, pend_r;
        cnt = 0; pending = 1'b0; commits = 0; pend_r = '0;
        auto_en = 1'b0; tick();
        auto_period = 6'(p);
        auto_en = 1'b1;
        u0 = upd_total;
        for (int i = 0; i < 10; i++) begin
            r = 16'($urandom);
            rand_w = r;
            frame();
            if (pending) begin
                check_commit(name, pend_r);
                commits++;
            end else begin
                checks++;
                if (update_out !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_idle_frame%0d: upd=%0b expected 0", name, i, update_out);
                end
            end
            fire = (cnt + 1 == p);
            cnt  = fire ? 0 : cnt + 1;
            if (pending) pending = 1'b0;
            else if (fire) begin
                pending = 1'b1;
                pend_r  = r;
            end
            repeat (99) tick();
        end
        auto_en = 1'b0;
        if (pending) begin
            frame();
            check_commit({name, "_flush"}, pend_r);
            commits++;
        end
        tick();
        checks++;
        if (upd_total != u0 + commits) begin
            errors++;
            $display("FAIL %s_count: pulses=%0d expected %0d", name, upd_total - u0, commits);
        end
    endtask

    task automatic test_auto();
        int u0;
        run_auto(3, "auto_p3");
        run_auto(int'($urandom_range(1, 5)), "auto_rand");
        auto_period = 6'd0;
        auto_en = 1'b1;
        u0 = upd_total;
        for (int i = 0; i < 5; i++) begin
            frame();
            repeat (20) tick();
        end
        checks++;
        if (upd_total != u0 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL auto_period0: pulses=%0d busy=%0b expected 0 0", upd_total - u0, busy_out);
        end
        auto_en = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        int u0;
        logic [15:0] r1, r2;
        r1 = 16'($urandom);
        rand_w = r1;
        auto_period = 6'd1;
        auto_en = 1'b1;
        trigger = 1'b1;
        repeat (6) tick();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
        auto_en = 1'b0;
        repeat (4) tick();
        trigger = 1'b0;
        repeat (15) tick();
        u0 = upd_total;
        frame();
        check_commit("collision", r1);
        frame();
        repeat (3) tick();
        checks++;
        if (upd_total != u0 + 1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL collision_single: pulses=%0d busy=%0b expected 1 0", upd_total - u0, busy_out);
        end
        r1 = 16'($urandom);
        r2 = ~r1;
        press(r1);
        press(r2);
        u0 = upd_total;
        frame();
        check_commit("drop_in_arm", r1);
        frame();
        repeat (3) tick();
        checks++;
        if (upd_total != u0 + 1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL drop_in_arm_single: pulses=%0d busy=%0b expected 1 0", upd_total - u0, busy_out);
        end
    endtask

    task automatic test_reset_mid_arm();
        int u0;
        test_button_fold(16'hFFFF, "pre_reset");
        press(16'h0401);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({x_out, y_out, pop_out, update_out, busy_out} !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_arm: x=%0d y=%0d pop=%0b upd=%0b busy=%0b expected all 0",
                     x_out, y_out, pop_out, update_out, busy_out);
        end
        repeat (2) tick();
        #3;
        rst_n = 1'b1;
        u0 = upd_total;
        for (int i = 0; i < 3; i++) begin
            frame();
            repeat (5) tick();
        end
        checks++;
        if (upd_total != u0 || busy_out !== 1'b0 || x_out !== 11'd0) begin
            errors++;
            $display("FAIL reset_no_update: pulses=%0d busy=%0b x=%0d expected 0 0 0", upd_total - u0, busy_out, x_out);
        end
    endtask

    initial begin
        test_reset();
        test_button_fold(16'hFFFF, "button_fold_ffff");
        test_button_fold(16'h0401, "fold_boundary_0401");
        test_button_fold(16'h0000, "fold_zero");
        test_random();
        test_debounce();
        test_auto();
        test_collision();
        test_reset_mid_arm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_pop_scheduler.md
Name: sprite_pop_scheduler

Overview:
Sequences position and variant updates for the 256x256 pop sprite in the 720p HDMI pipeline. It takes requests from a debounced push button or from a frame-count auto timer, and draws a random top-left position and pop bit from the LFSR word. It folds that position into the legal on-screen range and commits it only on a new_frame pulse, so the sprite never tears mid-frame. Its outputs drive the sprite's x/y/pop inputs directly.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame
SPRITE_W, 256, sprite width in pixels
SPRITE_H, 256, sprite height in lines
DEBOUNCE_CYCLES, 742500, cycles trigger must be stable (10 ms at 74.25 MHz)

Ports:
clk_pixel_in  in  1  pixel clock
rst_n_in  in  1  asynchronous active-low reset
trigger_in  in  1  raw push button, asynchronous, active-high
new_frame_in  in  1  one-cycle pulse at frame start, from video_sig_gen
rand_in  in  16  free-running LFSR word
auto_en_in  in  1  enables periodic auto-pop
auto_period_in  in  6  frames between auto pops; 0 disables auto
x_out  out  11  committed sprite left edge, 0..H_ACTIVE-SPRITE_W
y_out  out  10  committed sprite top edge, 0..V_ACTIVE-SPRITE_H
pop_out  out  1  committed sprite variant select
update_out  out  1  one-cycle pulse on the commit cycle
busy_out  out  1  high while a request is in flight (CAPTURE/FOLD/ARM)

Behaviour:
- Reset is one clock and asynchronous active-low, as already decided.
- While rst_n_in=0: all outputs 0, FSM=IDLE, all counters 0, debounced level 0.
- Trigger path:
  - trigger_in passes through a 2-FF synchroniser.
  - The debounced level flips only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce resets the counter.
  - A rising edge of the debounced level produces a 1-cycle btn_req.
- Auto path:
  - When auto_en_in=1 and auto_period_in!=0, frame_cnt increments on each new_frame_in.
  - When frame_cnt+1 reaches auto_period_in on a new_frame_in, frame_cnt returns to 0 and a 1-cycle auto_req fires.
  - auto_en_in=0 holds frame_cnt at 0.
- req = btn_req OR auto_req. Coincident requests produce one request.
- FSM:
  - IDLE: on req, go to CAPTURE.
  - CAPTURE (1 cycle):
    - Latch xr = rand_in[10:0] and yr = {rand_in[4:0], rand_in[15:11]}.
    - Latch pend_pop = rand_in[0].
    - Go to FOLD.
  - FOLD: each cycle, if xr >= XR (XR = H_ACTIVE-SPRITE_W+1 = 1025), xr -= XR.
  - FOLD: in the same cycle, if yr >= YR (YR = V_ACTIVE-SPRITE_H+1 = 465), yr -= YR.
  - FOLD: when both are already in range, go to ARM. Worst case is 3 FOLD cycles at default parameters.
  - ARM: on new_frame_in=1, drive x_out<=xr, y_out<=yr, pop_out<=pend_pop and update_out<=1 (registered, same edge). Then return to IDLE.
- update_out is high for exactly 1 cycle per commit.
- busy_out=1 in CAPTURE, FOLD and ARM.
- Requests arriving while busy_out=1 are dropped, not queued.
- A new_frame_in seen before ARM is ignored by the FSM; the request waits for the next frame.
- Subtractions are unsigned at full operand width. Outputs are never outside range.
- Reset asserted mid-request aborts it. Outputs return to 0 and no update_out pulse occurs.
- x_out, y_out and pop_out hold their values between commits.

Test Plan:
- Bench overrides DEBOUNCE_CYCLES=4 throughout.
- Reset: assert rst_n_in=0 mid-ARM -> all outputs 0 immediately (async). After release, no update_out until a new request.
- Button fold: rand_in=16'hFFFF, trigger_in high for 10 cycles, then new_frame_in -> x_out=1022, y_out=93, pop_out=1, a single update_out pulse on the frame cycle, busy_out low the next cycle.
- Fold boundary: rand_in=16'h0401 -> x_out=0 (1025 folds to 0), y_out=32, pop_out=1. rand_in=16'h0000 -> x_out=0, y_out=0, pop_out=0.
- Debounce: trigger_in toggles every 2 cycles for 40 cycles, then low -> no request, busy_out stays 0. Held high 5+ cycles -> exactly one request.
- Auto: auto_en_in=1, auto_period_in=3, 10 new_frame_in pulses spaced 100 cycles -> update_out on frames 3, 6 and 9 only (commit on the frame after each request). auto_period_in=0 -> no updates.
- Collision: btn_req and auto_req in the same cycle -> one commit. A second trigger during ARM -> dropped, only one update_out.
